// File: rtl/divisible_by_n_stream.sv
// Serial divisibility detector.
// Accepts a binary number one bit per valid cycle, MSB-first or LSB-first
// (chosen at clear), and after every accepted bit reports the running
// remainder modulo DIVISOR plus a divisible flag. Only shifts, adds and a
// single conditional subtract are used; there is no divider.
module divisible_by_n_stream #(
  parameter int DIVISOR   = 3,
  parameter int CNT_WIDTH = 16,
  localparam int REM_W    = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 mode,
  input  logic                 din_valid,
  input  logic                 din,
  output logic                 dout_valid,
  output logic                 dout,
  output logic [REM_W-1:0]     rem,
  output logic [CNT_WIDTH-1:0] bit_count
);

  // Controller states: IDLE until the first bit of a number arrives.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam logic [REM_W:0]     DIV_C       = (REM_W + 1)'(DIVISOR);
  localparam logic [REM_W-1:0]   WEIGHT_INIT = REM_W'(1);
  localparam logic [REM_W-1:0]   REM_ZERO    = {REM_W{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};

  generate
    if (DIVISOR < 2 || DIVISOR > 256) begin : g_bad_divisor
      $error("divisible_by_n_stream: DIVISOR must lie in 2..256");
    end
  endgenerate

  // Reduce a value known to be below 2*DIVISOR into 0..DIVISOR-1.
  function automatic logic [REM_W-1:0] fold(input logic [REM_W:0] t);
    return (t >= DIV_C) ? REM_W'(t - DIV_C) : REM_W'(t);
  endfunction

  logic [0:0]           state_r;
  logic [REM_W-1:0]     rem_r;
  logic [REM_W-1:0]     weight_r;
  logic                 mode_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 dout_r;
  logic                 dout_valid_r;

  logic [0:0]           state_next_s;
  logic [REM_W-1:0]     base_rem_s;
  logic [REM_W-1:0]     base_weight_s;
  logic [CNT_WIDTH-1:0] base_cnt_s;
  logic                 eff_mode_s;
  logic [REM_W:0]       msb_t_s;
  logic [REM_W:0]       lsb_t_s;
  logic [REM_W-1:0]     rem_next_s;
  logic [REM_W-1:0]     weight_next_s;
  logic [CNT_WIDTH-1:0] cnt_next_s;

  // Operand selection: a clear in the same cycle as a bit starts from the
  // reset state and the freshly sampled mode.
  always_comb begin
    if (clear) begin
      base_rem_s    = REM_ZERO;
      base_weight_s = WEIGHT_INIT;
      base_cnt_s    = CNT_ZERO;
      eff_mode_s    = mode;
    end else begin
      base_rem_s    = rem_r;
      base_weight_s = weight_r;
      base_cnt_s    = cnt_r;
      eff_mode_s    = mode_r;
    end
  end

  // Remainder/weight update. MSB-first shifts the remainder; LSB-first adds
  // the current power-of-two weight and advances the weight.
  always_comb begin
    msb_t_s = {base_rem_s, din};
    lsb_t_s = {1'b0, base_rem_s} + (din ? {1'b0, base_weight_s} : {(REM_W + 1){1'b0}});
    if (eff_mode_s) begin
      rem_next_s    = fold(lsb_t_s);
      weight_next_s = fold({base_weight_s, 1'b0});
    end else begin
      rem_next_s    = fold(msb_t_s);
      weight_next_s = base_weight_s;
    end
    if (base_cnt_s == CNT_MAX) begin
      cnt_next_s = base_cnt_s;
    end else begin
      cnt_next_s = base_cnt_s + CNT_ONE;
    end
  end

  // Controller next state: any accepted bit enters ACCUM; clear alone returns to IDLE.
  always_comb begin
    case (state_r)
      IDLE: begin
        if (din_valid) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (din_valid) begin
          state_next_s = ACCUM;
        end else if (clear) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State registers: reset dominates, then accepted bit, then a bare clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      rem_r        <= REM_ZERO;
      weight_r     <= WEIGHT_INIT;
      mode_r       <= 1'b0;
      cnt_r        <= CNT_ZERO;
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      dout_valid_r <= din_valid;
      if (din_valid) begin
        rem_r    <= rem_next_s;
        weight_r <= weight_next_s;
        cnt_r    <= cnt_next_s;
        mode_r   <= eff_mode_s;
        dout_r   <= (rem_next_s == REM_ZERO);
      end else if (clear) begin
        rem_r    <= REM_ZERO;
        weight_r <= WEIGHT_INIT;
        cnt_r    <= CNT_ZERO;
        mode_r   <= mode;
        dout_r   <= 1'b0;
      end
    end
  end

  assign dout_valid = dout_valid_r;
  assign dout       = dout_r;
  assign rem        = rem_r;
  assign bit_count  = cnt_r;

endmodule

// File: tb/tb_divisible_by_n_stream.sv
// Self-checking bench: four instances (DIVISOR 3, 5, 7 and 8 with a 4-bit
// counter) share one input stream; a history-based reference model
// recomputes each remainder from the full list of accepted bits.
module tb_divisible_by_n_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic mode = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;

  logic dv3, dv5, dv7, dv8;
  logic dout3, dout5, dout7, dout8;
  logic [1:0] rem3;
  logic [2:0] rem5, rem7, rem8;
  logic [15:0] cnt3, cnt5, cnt7;
  logic [3:0] cnt8;

  int checks = 0;
  int errors = 0;

  bit hist [0:127];
  int n_m = 0;
  bit lsb_m = 1'b0;

  bit b3 [3] = '{1'b1, 1'b1, 1'b0};
  int e3_rem [3] = '{1, 0, 0};
  int e3_dout [3] = '{0, 1, 1};
  int e5_rem [3] = '{1, 1, 0};
  int e5_dout [3] = '{0, 0, 1};

  always #5 clk = ~clk;

  divisible_by_n_stream #(.DIVISOR(3), .CNT_WIDTH(16)) u_d3 (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode), .din_valid(din_valid), .din(din),
    .dout_valid(dv3), .dout(dout3), .rem(rem3), .bit_count(cnt3));
  divisible_by_n_stream #(.DIVISOR(5), .CNT_WIDTH(16)) u_d5 (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode), .din_valid(din_valid), .din(din),
    .dout_valid(dv5), .dout(dout5), .rem(rem5), .bit_count(cnt5));
  divisible_by_n_stream #(.DIVISOR(7), .CNT_WIDTH(16)) u_d7 (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode), .din_valid(din_valid), .din(din),
    .dout_valid(dv7), .dout(dout7), .rem(rem7), .bit_count(cnt7));
  divisible_by_n_stream #(.DIVISOR(8), .CNT_WIDTH(4)) u_d8 (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode), .din_valid(din_valid), .din(din),
    .dout_valid(dv8), .dout(dout8), .rem(rem8), .bit_count(cnt8));

  // Compare one observed value with its expectation and count the outcome.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t, bits=%0d)", tag, obs, exp_v, $time, n_m);
    end
  endtask

  // 2^pos mod d by repeated doubling.
  function automatic int pow2mod(input int d, input int pos);
    int p = 1 % d;
    for (int k = 0; k < pos; k++) p = (p * 2) % d;
    return p;
  endfunction

  // Value of the whole accepted bit history, mod d.
  function automatic int ref_rem(input int d);
    int acc = 0;
    int pos;
    for (int i = 0; i < n_m; i++) begin
      pos = lsb_m ? i : (n_m - 1 - i);
      acc = (acc + (hist[i] ? pow2mod(d, pos) : 0)) % d;
    end
    return acc;
  endfunction

  task automatic check_inst(input string nm, input int d, input int cmax,
                            input logic [31:0] rem_o, input logic dout_o,
                            input logic dv_o, input logic [31:0] cnt_o, input bit exp_dv);
    int r;
    r = ref_rem(d);
    check_val({nm, "_rem"}, rem_o, r);
    check_val({nm, "_dout"}, {31'd0, dout_o}, ((n_m > 0) && (r == 0)) ? 32'd1 : 32'd0);
    check_val({nm, "_dv"}, {31'd0, dv_o}, {31'd0, exp_dv});
    check_val({nm, "_cnt"}, cnt_o, (n_m > cmax) ? cmax : n_m);
  endtask

  // Apply one cycle of inputs, advance the model, check all instances.
  task automatic step(input bit v, input bit c, input bit m, input bit b, input bit r);
    din_valid = v; clear = c; mode = m; din = b; reset = r;
    @(posedge clk); #1;
    din_valid = 1'b0; clear = 1'b0; reset = 1'b0;
    if (r) begin
      n_m = 0; lsb_m = 1'b0;
    end else begin
      if (c) begin
        n_m = 0; lsb_m = m;
      end
      if (v) begin
        hist[n_m] = b;
        n_m++;
      end
    end
    check_inst("d3", 3, 65535, {30'd0, rem3}, dout3, dv3, {16'd0, cnt3}, v && !r);
    check_inst("d5", 5, 65535, {29'd0, rem5}, dout5, dv5, {16'd0, cnt5}, v && !r);
    check_inst("d7", 7, 65535, {29'd0, rem7}, dout7, dv7, {16'd0, cnt7}, v && !r);
    check_inst("d8", 8, 15, {29'd0, rem8}, dout8, dv8, {28'd0, cnt8}, v && !r);
  endtask

  initial begin
    int dv_seen;
    int frozen;
    bit smode;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("rst_rem7", {29'd0, rem7}, 32'd0);
    check_val("rst_dout7", {31'd0, dout7}, 32'd0);

    // DIVISOR=3, MSB-first 1,1,0 (=6).
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, b3[i], 1'b0);
      check_val("d3_dir_rem", {30'd0, rem3}, e3_rem[i]);
      check_val("d3_dir_dout", {31'd0, dout3}, e3_dout[i]);
      check_val("d3_dir_cnt", {16'd0, cnt3}, i + 1);
    end

    // DIVISOR=5, LSB-first 1,0,1 (=5).
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, (i != 1), 1'b0);
      check_val("d5_dir_rem", {29'd0, rem5}, e5_rem[i]);
      check_val("d5_dir_dout", {31'd0, dout5}, e5_dout[i]);
    end

    // Leading zeros stay divisible.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check_val("zeros_dout7", {31'd0, dout7}, 32'd1);
    end

    // Mid-stream clear with a bit, switching MSB -> LSB.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("cv_rem7", {29'd0, rem7}, 32'd1);
    check_val("cv_dout7", {31'd0, dout7}, 32'd0);
    check_val("cv_cnt7", {16'd0, cnt7}, 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Reset mid-number while a bit is offered.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("rstmid_rem7", {29'd0, rem7}, 32'd0);
    check_val("rstmid_dv7", {31'd0, dv7}, 32'd0);
    check_val("rstmid_cnt7", {16'd0, cnt7}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random 64-bit streams with gaps; first ones MSB-first, then random mode.
    for (int s = 0; s < 6; s++) begin
      smode = (s < 3) ? 1'b0 : 1'($urandom_range(0, 1));
      step(1'b0, 1'b1, smode, 1'b0, 1'b0);
      dv_seen = 0;
      for (int i = 0; i < 64; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
          if (dv7) dv_seen++;
        end
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        if (dv7) dv_seen++;
      end
      check_val("rnd_dv_count7", dv_seen, 32'd64);
    end

    // DIVISOR=8 LSB-first, 20 bits: rem freezes after bit 3, counter saturates.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frozen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (i == 2) frozen = int'(rem8);
      if (i > 2) check_val("d8_frozen", {29'd0, rem8}, frozen);
    end
    check_val("d8_sat_cnt", {28'd0, cnt8}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
